// File: rtl/hazard_scoreboard.sv
// Load-use scoreboard and stage-control unit for a 1- or 2-wide issue pipeline.
// Per-register countdowns track outstanding loads; the FSM keeps an exception alive across long stalls.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal issue; exception flushes immediately if no stall
// ST_EXC   | exception pending behind a long stall; flush every cycle
module hazard_scoreboard #(
   parameter int ISSUE      = 2,
   parameter int LOAD_LAT   = 2,
   parameter int FIFO_FETCH = 1,
   parameter int CNT_W      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_stall,
   input  logic                 d_stall,
   input  logic                 E_alu_stall,
   input  logic [ISSUE-1:0]     D_valid,
   input  logic [5*ISSUE-1:0]   D_rs,
   input  logic [5*ISSUE-1:0]   D_rt,
   input  logic [ISSUE-1:0]     D_wen,
   input  logic [5*ISSUE-1:0]   D_waddr,
   input  logic [ISSUE-1:0]     D_load,
   input  logic                 E_branch_taken,
   input  logic                 M_except,
   output logic                 longest_stall,
   output logic                 F_ena,
   output logic                 D_ena,
   output logic                 E_ena,
   output logic                 M_ena,
   output logic                 W_ena,
   output logic                 F_flush,
   output logic                 D_flush,
   output logic                 E_flush,
   output logic                 M_flush,
   output logic                 W_flush,
   output logic                 D_slave_issue,
   output logic [31:0]          lw_pending,
   output logic [CNT_W-1:0]     stall_cycles
);

   typedef enum logic {ST_RUN, ST_EXC} state_t;

   localparam logic [2:0] LAT = 3'(LOAD_LAT);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_exc_flush;
   logic [2:0]        r_cnt [32];
   logic [2:0]        w_cnt_nxt [32];
   logic [31:0]       w_pend;
   logic [CNT_W-1:0]  r_stall_cycles;

   logic [4:0]        w_rs0, w_rt0, w_waddr0;
   logic [4:0]        w_rs1, w_rt1, w_waddr1;
   logic              w_valid1, w_wen1, w_load1;
   logic              w_hz0, w_hz1, w_raw;
   logic              w_issue0, w_issue1;

   assign w_rs0    = D_rs[4:0];
   assign w_rt0    = D_rt[4:0];
   assign w_waddr0 = D_waddr[4:0];

   generate
      if (ISSUE == 2) begin : g_dual
         assign w_rs1    = D_rs[9:5];
         assign w_rt1    = D_rt[9:5];
         assign w_waddr1 = D_waddr[9:5];
         assign w_valid1 = D_valid[1];
         assign w_wen1   = D_wen[1];
         assign w_load1  = D_load[1];
      end else begin : g_single
         assign w_rs1    = 5'd0;
         assign w_rt1    = 5'd0;
         assign w_waddr1 = 5'd0;
         assign w_valid1 = 1'b0;
         assign w_wen1   = 1'b0;
         assign w_load1  = 1'b0;
      end
   endgenerate

   always_comb begin
      for (int r = 0; r < 32; r++) begin
         w_pend[r] = (r_cnt[r] != 3'd0);
      end
      w_pend[0] = 1'b0;
   end

   assign lw_pending    = w_pend;
   assign longest_stall = E_alu_stall | i_stall | d_stall;

   assign w_hz0 = D_valid[0] & (w_pend[w_rs0] | w_pend[w_rt0]);
   assign w_hz1 = w_valid1 & (w_pend[w_rs1] | w_pend[w_rt1]);
   assign w_raw = D_wen[0] & (w_waddr0 != 5'd0) & ((w_rs1 == w_waddr0) | (w_rt1 == w_waddr0));

   assign D_slave_issue = w_valid1 & ~w_hz1 & ~w_hz0 & ~longest_stall & ~w_raw;

   assign D_ena = ~(w_hz0 | longest_stall);
   assign F_ena = D_ena | ((FIFO_FETCH != 0) & d_stall);
   assign E_ena = ~longest_stall;
   assign M_ena = ~longest_stall;
   assign W_ena = ~longest_stall;

   always_comb begin
      w_state_nxt = r_state;
      w_exc_flush = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (M_except) begin
               w_exc_flush = 1'b1;
               if (longest_stall) w_state_nxt = ST_EXC;
            end
         end
         ST_EXC: begin
            w_exc_flush = 1'b1;
            if (!longest_stall) w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   assign F_flush = 1'b0;
   assign W_flush = 1'b0;
   assign D_flush = w_exc_flush | E_branch_taken;
   assign E_flush = w_exc_flush | E_branch_taken;
   assign M_flush = w_exc_flush;

   assign w_issue0 = D_ena & ~D_flush & D_valid[0];
   assign w_issue1 = D_ena & ~D_flush & w_valid1 & D_slave_issue;

   // Slave write is applied last so it wins when both slots target one register.
   always_comb begin
      for (int r = 0; r < 32; r++) begin
         w_cnt_nxt[r] = r_cnt[r];
         if (!longest_stall && r_cnt[r] != 3'd0) w_cnt_nxt[r] = r_cnt[r] - 3'd1;
      end
      if (w_issue0 && D_wen[0] && w_waddr0 != 5'd0)
         w_cnt_nxt[w_waddr0] = D_load[0] ? LAT : 3'd0;
      if (w_issue1 && w_wen1 && w_waddr1 != 5'd0)
         w_cnt_nxt[w_waddr1] = w_load1 ? LAT : 3'd0;
      if (w_exc_flush) begin
         for (int r = 0; r < 32; r++) w_cnt_nxt[r] = 3'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_RUN;
         r_stall_cycles <= '0;
         for (int r = 0; r < 32; r++) r_cnt[r] <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         for (int r = 0; r < 32; r++) r_cnt[r] <= w_cnt_nxt[r];
         if (!D_ena && r_stall_cycles != {CNT_W{1'b1}})
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
   end

   assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: combinational vector table under reset, directed
// multi-cycle sequences, and randomized traffic against a register-readiness model.
module tb_hazard_scoreboard;
   localparam int LOAD_LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        i_stall, d_stall, E_alu_stall, E_branch_taken, M_except;
   logic [1:0]  D_valid, D_wen, D_load;
   logic [9:0]  D_rs, D_rt, D_waddr;
   logic        longest_stall, F_ena, D_ena, E_ena, M_ena, W_ena;
   logic        F_flush, D_flush, E_flush, M_flush, W_flush, D_slave_issue;
   logic [31:0] lw_pending, stall_cycles;

   hazard_scoreboard #(.ISSUE(2), .LOAD_LAT(LOAD_LAT), .FIFO_FETCH(1), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall), .E_alu_stall(E_alu_stall),
      .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt), .D_wen(D_wen), .D_waddr(D_waddr),
      .D_load(D_load), .E_branch_taken(E_branch_taken), .M_except(M_except),
      .longest_stall(longest_stall), .F_ena(F_ena), .D_ena(D_ena), .E_ena(E_ena),
      .M_ena(M_ena), .W_ena(W_ena), .F_flush(F_flush), .D_flush(D_flush),
      .E_flush(E_flush), .M_flush(M_flush), .W_flush(W_flush),
      .D_slave_issue(D_slave_issue), .lw_pending(lw_pending), .stall_cycles(stall_cycles));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: remaining forwarding delay per register, in non-stalled cycles.
   int          rem [32];
   bit          m_exc;
   logic [31:0] m_stall;
   bit          e_ls, e_dena, e_fena, e_eena, e_dfl, e_mfl, e_slave, e_exc;
   logic [31:0] e_pend;

   function automatic bit pend(int r);
      return (r != 0) && (rem[r] > 0);
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) rem[r] = 0;
      m_exc = 0;
      m_stall = '0;
   endtask

   task automatic model_eval();
      int rs0, rt0, wa0, rs1, rt1;
      bit hz0, hz1, raw;
      rs0 = int'(D_rs[4:0]); rt0 = int'(D_rt[4:0]); wa0 = int'(D_waddr[4:0]);
      rs1 = int'(D_rs[9:5]); rt1 = int'(D_rt[9:5]);
      e_ls    = E_alu_stall | i_stall | d_stall;
      hz0     = D_valid[0] && (pend(rs0) || pend(rt0));
      hz1     = D_valid[1] && (pend(rs1) || pend(rt1));
      raw     = D_wen[0] && wa0 != 0 && (rs1 == wa0 || rt1 == wa0);
      e_slave = D_valid[1] && !hz1 && !hz0 && !e_ls && !raw;
      e_dena  = !(hz0 || e_ls);
      e_fena  = e_dena || d_stall;
      e_eena  = !e_ls;
      e_exc   = m_exc || M_except;
      e_dfl   = e_exc || E_branch_taken;
      e_mfl   = e_exc;
      for (int r = 0; r < 32; r++) e_pend[r] = pend(r);
   endtask

   task automatic model_update();
      bit iss0, iss1;
      int wa0, wa1;
      model_eval();
      wa0 = int'(D_waddr[4:0]); wa1 = int'(D_waddr[9:5]);
      iss0 = e_dena && !e_dfl && D_valid[0];
      iss1 = e_dena && !e_dfl && D_valid[1] && e_slave;
      if (e_exc) begin
         for (int r = 0; r < 32; r++) rem[r] = 0;
      end else begin
         for (int r = 0; r < 32; r++) if (rem[r] > 0 && !e_ls) rem[r]--;
         if (iss0 && D_wen[0] && wa0 != 0) rem[wa0] = D_load[0] ? LOAD_LAT : 0;
         if (iss1 && D_wen[1] && wa1 != 0) rem[wa1] = D_load[1] ? LOAD_LAT : 0;
      end
      if (!e_dena && m_stall != 32'hFFFF_FFFF) m_stall++;
      m_exc = m_exc ? e_ls : (M_except && e_ls);
   endtask

   logic        cap_dena, cap_dfl, cap_efl, cap_mfl, cap_slave;
   logic [31:0] cap_pend, cap_stall;

   task automatic check_model();
      model_eval();
      chk("longest_stall", longest_stall, e_ls);
      chk("F_ena", F_ena, e_fena);
      chk("D_ena", D_ena, e_dena);
      chk("EMW_ena", {E_ena, M_ena, W_ena}, {3{e_eena}});
      chk("flush_DEM", {D_flush, E_flush, M_flush}, {e_dfl, e_dfl, e_mfl});
      chk("flush_FW", {F_flush, W_flush}, 2'b00);
      chk("D_slave_issue", D_slave_issue, e_slave);
      chk("lw_pending", lw_pending, e_pend);
      chk("stall_cycles", stall_cycles, m_stall);
   endtask

   // Entered and left at a falling edge; inputs are already applied.
   task automatic step();
      #1;
      check_model();
      cap_dena = D_ena; cap_dfl = D_flush; cap_efl = E_flush; cap_mfl = M_flush;
      cap_slave = D_slave_issue; cap_pend = lw_pending; cap_stall = stall_cycles;
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic clear_in();
      i_stall = 0; d_stall = 0; E_alu_stall = 0; E_branch_taken = 0; M_except = 0;
      D_valid = '0; D_wen = '0; D_load = '0; D_rs = '0; D_rt = '0; D_waddr = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      clear_in();
      model_reset();
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   task automatic count_stall(output int n);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (cap_dena) return;
         n++;
      end
      checks++;
      failures++;
      $display("FAIL stall_timeout actual=%0d required=<20", n);
   endtask

   typedef struct {
      logic [2:0] stl;   // {E_alu, i, d}
      logic [1:0] vld;
      logic [9:0] rs, rt, wa;
      logic [1:0] wen, ld;
      logic       br, ex;
      logic [6:0] exp;   // {D_ena, F_ena, E_ena, D_flush, E_flush, M_flush, D_slave_issue}
   } vec_t;

   vec_t tv [13];

   function automatic vec_t mk(logic [2:0] stl, logic [1:0] vld, logic [9:0] rs, logic [9:0] rt,
                               logic [9:0] wa, logic [1:0] wen, logic br, logic ex, logic [6:0] exp);
      vec_t v;
      v.stl = stl; v.vld = vld; v.rs = rs; v.rt = rt; v.wa = wa;
      v.wen = wen; v.ld = 2'b00; v.br = br; v.ex = ex; v.exp = exp;
      return v;
   endfunction

   initial begin
      int n;
      clear_in();
      model_reset();
      tv[0]  = mk(3'b000, 2'b00, 10'd0, 10'd0, 10'd0, 2'b00, 0, 0, 7'b1110000);
      tv[1]  = mk(3'b000, 2'b11, {5'd3, 5'd1}, {5'd2, 5'd2}, {5'd6, 5'd3}, 2'b11, 0, 0, 7'b1110000);
      tv[2]  = mk(3'b000, 2'b11, {5'd4, 5'd1}, {5'd2, 5'd2}, {5'd6, 5'd3}, 2'b11, 0, 0, 7'b1110001);
      tv[3]  = mk(3'b000, 2'b11, {5'd4, 5'd1}, {5'd3, 5'd2}, {5'd6, 5'd3}, 2'b11, 0, 0, 7'b1110000);
      tv[4]  = mk(3'b001, 2'b11, {5'd4, 5'd1}, {5'd2, 5'd2}, {5'd6, 5'd3}, 2'b11, 0, 0, 7'b0100000);
      tv[5]  = mk(3'b010, 2'b11, {5'd4, 5'd1}, {5'd2, 5'd2}, {5'd6, 5'd3}, 2'b11, 0, 0, 7'b0000000);
      tv[6]  = mk(3'b100, 2'b11, {5'd4, 5'd1}, {5'd2, 5'd2}, {5'd6, 5'd3}, 2'b11, 0, 0, 7'b0000000);
      tv[7]  = mk(3'b000, 2'b11, {5'd4, 5'd1}, {5'd2, 5'd2}, {5'd6, 5'd3}, 2'b11, 1, 0, 7'b1111101);
      tv[8]  = mk(3'b000, 2'b11, {5'd4, 5'd1}, {5'd2, 5'd2}, {5'd6, 5'd3}, 2'b11, 0, 1, 7'b1111111);
      tv[9]  = mk(3'b000, 2'b11, {5'd4, 5'd1}, {5'd2, 5'd2}, {5'd6, 5'd3}, 2'b11, 1, 1, 7'b1111111);
      tv[10] = mk(3'b000, 2'b11, {5'd0, 5'd1}, {5'd0, 5'd2}, {5'd6, 5'd0}, 2'b11, 0, 0, 7'b1110001);
      tv[11] = mk(3'b000, 2'b01, {5'd3, 5'd1}, {5'd2, 5'd2}, {5'd6, 5'd3}, 2'b11, 0, 0, 7'b1110000);
      tv[12] = mk(3'b000, 2'b10, {5'd4, 5'd1}, {5'd2, 5'd2}, {5'd6, 5'd3}, 2'b11, 0, 0, 7'b1110001);

      // Reset held: state stays at reset values, combinational decode is exercised.
      rst = 1;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         {E_alu_stall, i_stall, d_stall} = tv[i].stl;
         D_valid = tv[i].vld; D_rs = tv[i].rs; D_rt = tv[i].rt; D_waddr = tv[i].wa;
         D_wen = tv[i].wen; D_load = tv[i].ld; E_branch_taken = tv[i].br; M_except = tv[i].ex;
         #1;
         chk($sformatf("vec%0d", i), {D_ena, F_ena, E_ena, D_flush, E_flush, M_flush, D_slave_issue}, tv[i].exp);
         chk($sformatf("vec%0d_reset_state", i), {lw_pending, stall_cycles}, 64'd0);
      end

      // Load-use: lw $5 then consumer stalls exactly LOAD_LAT cycles.
      do_reset();
      D_valid = 2'b01; D_wen = 2'b01; D_load = 2'b01; D_waddr = {5'd0, 5'd5};
      step();
      chk("lw5_issue_dena", cap_dena, 1'b1);
      clear_in(); D_valid = 2'b01; D_rs = {5'd0, 5'd5};
      count_stall(n);
      chk("lw5_stall_len", n, 2);
      chk("lw5_stall_cycles", cap_stall, 32'd2);

      // Long stall freezes the countdown.
      do_reset();
      D_valid = 2'b01; D_wen = 2'b01; D_load = 2'b01; D_waddr = {5'd0, 5'd5};
      step();
      clear_in(); D_valid = 2'b01; D_rs = {5'd0, 5'd5}; i_stall = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("istall_pend5", cap_pend[5], 1'b1);
      end
      i_stall = 0;
      count_stall(n);
      chk("istall_post_len", n, 2);

      // Load to $0 never pends; dual write to $7, slave wins.
      do_reset();
      D_valid = 2'b01; D_wen = 2'b01; D_load = 2'b01; D_waddr = {5'd0, 5'd0};
      step();
      clear_in(); D_valid = 2'b01; D_rs = {5'd0, 5'd0};
      step();
      chk("r0_dena", cap_dena, 1'b1);
      chk("r0_pend", cap_pend, 32'd0);
      D_valid = 2'b11; D_wen = 2'b11; D_load = 2'b01; D_waddr = {5'd7, 5'd7};
      D_rs = {5'd1, 5'd2}; D_rt = '0;
      step();
      chk("dual7_slave", cap_slave, 1'b1);
      clear_in();
      step();
      chk("dual7_pend", cap_pend[7], 1'b0);

      // Exception during a 3-cycle ALU stall.
      do_reset();
      D_valid = 2'b01; D_wen = 2'b01; D_load = 2'b01; D_waddr = {5'd0, 5'd6};
      step();
      clear_in(); E_alu_stall = 1; M_except = 1;
      step();
      chk("exc_c0_flush", {cap_dfl, cap_efl, cap_mfl}, 3'b111);
      chk("exc_c0_pend6", cap_pend[6], 1'b1);
      M_except = 0;
      for (int k = 1; k < 3; k++) begin
         step();
         chk("exc_stall_flush", {cap_dfl, cap_efl, cap_mfl}, 3'b111);
         chk("exc_stall_pend", cap_pend, 32'd0);
      end
      E_alu_stall = 0;
      step();
      chk("exc_release_flush", {cap_dfl, cap_efl, cap_mfl}, 3'b111);
      step();
      chk("exc_after_flush", {cap_dfl, cap_efl, cap_mfl}, 3'b000);

      // Branch suppresses a load issue.
      do_reset();
      D_valid = 2'b01; D_wen = 2'b01; D_load = 2'b01; D_waddr = {5'd0, 5'd9}; E_branch_taken = 1;
      step();
      chk("br_flush", {cap_dfl, cap_efl, cap_mfl}, 3'b110);
      clear_in();
      step();
      chk("br_pend9", cap_pend[9], 1'b0);

      // Reset while an exception is pending.
      do_reset();
      E_alu_stall = 1; M_except = 1;
      step();
      M_except = 0;
      step();
      do_reset();
      step();
      chk("rst_exc_flush", {cap_dfl, cap_efl, cap_mfl}, 3'b000);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c % 700 == 699) do_reset();
         D_valid = 2'($urandom); D_wen = 2'($urandom); D_load = 2'($urandom);
         D_rs    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         D_rt    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         D_waddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         i_stall        = ($urandom_range(0, 9) == 0);
         d_stall        = ($urandom_range(0, 9) == 0);
         E_alu_stall    = ($urandom_range(0, 7) == 0);
         E_branch_taken = ($urandom_range(0, 15) == 0);
         M_except       = ($urandom_range(0, 31) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
